instr_fetch: RTL and testbench

- Fetch stage that sits directly upstream of the control unit and decoder.
- Owns the PC register and issues word reads to instruction memory over a request/grant/rvalid handshake.
- Presents each fetched instruction and its PC to decode with a valid/ready handshake.
- Accepts PC redirects (branch taken or jump, i.e. PC_src plus the target) from the execute path, and discards any stale fetch in flight.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/pc_next_gen.sv | 17 +
 rtl/instr_fetch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants used by the fetch stage.
package riscv_pkg;

  localparam int unsigned     ILEN             = 32;
  localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;
  localparam logic [31:0]     RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/pc_next_gen.sv
// Next-PC generation: sequential PC (pc + 4, wrapping) and the word-aligned redirect target.
module pc_next_gen #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc_target,
  output logic [ADDR_W-1:0] pc_next
);

  always_comb begin
    pc_target = {redirect_target[ADDR_W-1:2], 2'b00};
    pc_next   = redirect ? pc_target : pc + ADDR_W'(4);
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the imem req/gnt/rvalid handshake and a
// valid/ready instruction interface to decode. Define IF_PERF_CNT_EN to add fetch/flush counters.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [ILEN-1:0]   imem_rdata,
  output logic [ILEN-1:0]   instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_target;
  logic [ADDR_W-1:0] pc_next;
  logic              discard;

  pc_next_gen #(.ADDR_W(ADDR_W)) u_pc_next_gen (
    .pc              (pc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .pc_target       (pc_target),
    .pc_next         (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= NOP;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      discard     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            pc        <= pc_target;
            imem_addr <= pc_target;
          end else begin
            imem_addr <= pc;
          end
          imem_req <= 1'b1;
          state    <= REQ;
        end
        REQ: begin
          // imem_req low here means the request was withdrawn by a redirect last cycle
          if (!imem_req) begin
            if (redirect) begin
              pc        <= pc_target;
              imem_addr <= pc_target;
            end
            imem_req <= 1'b1;
          end else if (imem_gnt) begin
            imem_req <= 1'b0;
            state    <= WAIT;
            if (redirect) begin
              pc      <= pc_target;
              discard <= 1'b1;
            end
          end else if (redirect) begin
            pc        <= pc_target;
            imem_addr <= pc_target;
            imem_req  <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (discard || redirect) begin
              discard   <= 1'b0;
              pc        <= redirect ? pc_target : pc;
              imem_addr <= redirect ? pc_target : pc;
              imem_req  <= 1'b1;
              state     <= REQ;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc_next;
              state       <= HOLD;
            end
          end else if (redirect) begin
            pc      <= pc_target;
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            pc          <= pc_target;
            imem_addr   <= pc_target;
            imem_req    <= 1'b1;
            state       <= REQ;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            imem_addr   <= pc;
            imem_req    <= 1'b1;
            state       <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  // A HOLD redirect counts as a flush, not a delivery, even with instr_ready high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (instr_valid && instr_ready && !redirect)
        fetch_cnt <= fetch_cnt + 32'd1;
      if ((state == WAIT && imem_rvalid && (discard || redirect)) ||
          (instr_valid && redirect))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; the bench plays the instruction memory and decode.
module tb_instr_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt       (fetch_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   {31'd0, imem_req},    32'd0);
    check({tag, "_addr"},  imem_addr,            32'h0000_0000);
    check({tag, "_instr"}, instr,                32'h0000_0013);
    check({tag, "_ipc"},   instr_pc,             32'h0000_0000);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_target = '0;
    step(); step();
    check_reset_values("rst");
`ifdef IF_PERF_CNT_EN
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
`endif

    // 1: first fetch at address 0
    rst_n = 1'b1;
    step();
    check("t1_req", {31'd0, imem_req}, 32'd1);
    check("t1_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    step();
    check("t1_req_drop", {31'd0, imem_req}, 32'd0);
    check("t1_wait_valid", {31'd0, instr_valid}, 32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    check("t1_valid", {31'd0, instr_valid}, 32'd1);
    check("t1_instr", instr, 32'h0050_0093);
    check("t1_ipc", instr_pc, 32'h0);

    // 2: decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_valid", {31'd0, instr_valid}, 32'd1);
      check("t2_hold_instr", instr, 32'h0050_0093);
      check("t2_hold_req", {31'd0, imem_req}, 32'd0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t2_valid_drop", {31'd0, instr_valid}, 32'd0);
    check("t2_req", {31'd0, imem_req}, 32'd1);
    check("t2_addr", imem_addr, 32'h4);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_8113;
    step();
    imem_rvalid = 1'b0;
    check("t2_instr", instr, 32'h0010_8113);
    check("t2_ipc", instr_pc, 32'h4);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t2_next_addr", imem_addr, 32'h8);

    // 3: redirect while waiting on address 8
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; redirect = 1'b1; redirect_target = 32'h0000_0103;
    step();
    redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check("t3_no_valid", {31'd0, instr_valid}, 32'd0);
    check("t3_req", {31'd0, imem_req}, 32'd1);
    check("t3_addr", imem_addr, 32'h100);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0513;
    step();
    imem_rvalid = 1'b0;
    check("t3_valid", {31'd0, instr_valid}, 32'd1);
    check("t3_instr", instr, 32'h0000_0513);
    check("t3_ipc", instr_pc, 32'h100);
`ifdef IF_PERF_CNT_EN
    check("t3_flush_cnt", flush_cnt, 32'd1);
    check("t3_fetch_cnt", fetch_cnt, 32'd2);
`endif

    // 4: redirect in HOLD beats a simultaneous ready
    redirect = 1'b1; redirect_target = 32'h0000_0200; instr_ready = 1'b1;
    step();
    redirect = 1'b0; instr_ready = 1'b0;
    check("t4_valid_drop", {31'd0, instr_valid}, 32'd0);
    check("t4_addr", imem_addr, 32'h200);
    check("t4_req", {31'd0, imem_req}, 32'd1);
`ifdef IF_PERF_CNT_EN
    check("t4_flush_cnt", flush_cnt, 32'd2);
    check("t4_fetch_cnt", fetch_cnt, 32'd2);
`endif
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0593;
    step();
    imem_rvalid = 1'b0;
    check("t4_ipc", instr_pc, 32'h200);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t4_next_addr", imem_addr, 32'h204);

    // REQ without grant: address stable, then a redirect withdraws and reissues
    step();
    check("req_stall_req", {31'd0, imem_req}, 32'd1);
    check("req_stall_addr", imem_addr, 32'h204);
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    check("req_redir_withdraw", {31'd0, imem_req}, 32'd0);
    check("req_redir_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("req_redir_reissue", {31'd0, imem_req}, 32'd1);
    check("req_redir_addr2", imem_addr, 32'hFFFF_FFFC);

    // 5: fetch at the top of the address space wraps to 0
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_006F;
    step();
    imem_rvalid = 1'b0;
    check("t5_ipc", instr_pc, 32'hFFFF_FFFC);
    check("t5_instr", instr, 32'h0000_006F);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t5_wrap_addr", imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("t5_fetch_cnt", fetch_cnt, 32'd4);
`endif

    // 6: reset asserted in WAIT, rvalid arriving during reset is ignored
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_async");
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    step(); step();
    imem_rvalid = 1'b0;
    check_reset_values("t6_held");
    rst_n = 1'b1;
    step();
    check("t6_restart_req", {31'd0, imem_req}, 32'd1);
    check("t6_restart_addr", imem_addr, 32'h0);
    check("t6_restart_valid", {31'd0, instr_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
    check("t6_fetch_cnt", fetch_cnt, 32'd0);
    check("t6_flush_cnt", flush_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
